data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, sets storage depth in 32-bit words; it SHALL be a power of two, from 16 to 65536.
REQ-002 Parameter LATENCY, default 2, sets the cycles from request acceptance to data_ready; the legal range SHALL be 1..15.
REQ-003 Port clk, input, 1 bit: the single clock; the block SHALL use only its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous reset, active-high.
REQ-005 Port clk_en, input, 1 bit: clock enable; while low, all state SHALL hold.
REQ-006 Port data_rd_en, input, 1 bit: read request.
REQ-007 Port data_wr_en, input, 1 bit: write request.
REQ-008 Port data_rd_wr_ctrl, input, 2 bits: access size; 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 Port addr, input, 32 bits: byte address.
REQ-010 Port data_in, input, 32 bits: write data, right-aligned.
REQ-011 Port data_out, output, 32 bits: read data, right-aligned and zero-extended.
REQ-012 Port data_ready, output, 1 bit: one-cycle completion pulse.
REQ-013 Port access_err, output, 1 bit: one-cycle error pulse, coincident with data_ready.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP; all transitions SHALL occur only on clk edges where clk_en = 1.
REQ-015 In IDLE, a request (data_rd_en or data_wr_en high) SHALL be accepted at the edge.
  - On acceptance, addr, size, data_in and the request type SHALL be latched.
  - Input changes after acceptance SHALL be ignored until the access completes.
REQ-016 State progression:
  - LATENCY = 1: IDLE -> RESP.
  - Otherwise: IDLE -> WAIT; a counter holds WAIT for LATENCY-1 cycles, then RESP.
  - RESP -> IDLE, unconditionally.
REQ-017 data_ready SHALL be high exactly during the RESP cycle, i.e. LATENCY cycles after the accepting edge.
REQ-018 A new request SHALL be accepted no earlier than the first IDLE edge after RESP; a request held high continuously SHALL produce back-to-back accesses separated by one IDLE cycle.
REQ-019 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo the storage size.
REQ-020 The write SHALL commit at the edge that enters RESP; only the selected byte lanes SHALL be modified.
  - byte: lane addr[1:0].
  - half: lanes addr[1] x2 and addr[1] x2 + 1.
REQ-021 Read data SHALL be shifted right by 8 x addr[1:0] and masked to the access size; bits above the size SHALL be 0, and sign extension is left to the core.
REQ-022 Read data SHALL reflect any write committed before the accepting edge.
REQ-023 Error conditions SHALL raise access_err for the RESP cycle, with data_out = 0 and no storage modification:
  - size 11;
  - half access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - data_rd_en and data_wr_en both high at acceptance.
REQ-024 Outside RESP, data_out SHALL hold its last value and access_err SHALL be 0.
REQ-025 If clk_en is low during WAIT or RESP, the counter and outputs SHALL freeze, stretching data_ready for as many cycles as clk_en is low.

Reset
REQ-026 While rst is high:
  - the state SHALL be IDLE and the counter 0;
  - data_out, data_ready and access_err SHALL be 0;
  - latched request fields SHALL be 0.
REQ-027 Reset asserted mid-access SHALL abort the access: a pending write SHALL be discarded and no data_ready SHALL follow.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-029 The size encoding enum (MEM_BYTE, MEM_HALF, MEM_WORD) and the FSM state enum SHALL live in riscv_definitions.
REQ-030 Storage SHALL be the sub-module dmem_array: single-port, with 4-bit byte-write enable and synchronous write; the FSM, lane alignment and error logic SHALL live in data_mem_responder.

Verification
REQ-031 Word write then read, LATENCY = 2:
  - stimulus: write 0xDEADBEEF to 0x40, then read 0x40;
  - response: data_ready two cycles after each acceptance; read data_out = 0xDEADBEEF.
REQ-032 Byte write and byte reads:
  - stimulus: byte write 0xA5 to 0x41 over the word 0x00000000, then byte read 0x41 and word read 0x40;
  - response: byte read = 0x000000A5; word read = 0x0000A500.
REQ-033 Misaligned and illegal accesses:
  - stimulus: half write to 0x43, word read from 0x42, size 11;
  - response: each gives data_ready and access_err high for 1 cycle; data_out = 0; memory unchanged.
REQ-034 Reset mid-access:
  - stimulus: rst pulsed during WAIT of a write of 0x12345678 to 0x80;
  - response: no data_ready; a later read of 0x80 returns the prior value.
REQ-035 clk_en stall and address wrap:
  - stimulus: clk_en low for 3 cycles during RESP; with DEPTH_WORDS = 16, an access to address 0x44;
  - response: data_ready stays high for 4 cycles; address 0x44 aliases 0x04.
REQ-036 Sweep LATENCY over 1, 2 and 15; response: data_ready occurs at exactly LATENCY cycles after acceptance in each case.

Source files
------------

// File: rtl/riscv_definitions.sv
// rtl/riscv_definitions.sv - shared access-size and responder-state types
// Purpose: size encoding for data accesses, responder FSM states and the
//          byte-lane mask helper used by the data memory responder.
// Ports:   none (package).
package riscv_definitions;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } resp_state_t;

   localparam int WORD_BITS = 32;

   // Byte lanes touched by an access of the given size at the given offset.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         MEM_BYTE: lane_mask = 4'b0001 << offset;
         MEM_HALF: lane_mask = 4'b0011 << {offset[1], 1'b0};
         MEM_WORD: lane_mask = 4'b1111;
         default:  lane_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word storage with byte-write enables
// Purpose: DEPTH_WORDS x 32-bit storage, synchronous byte-lane write,
//          combinational read of the addressed word. Never cleared.
// Ports:   clk     - clock (rising edge)
//          byte_en - per-lane write enable, lane 0 = bits 7:0
//          index   - word index shared by read and write
//          wdata   - lane-aligned write data
//          rdata   - addressed word
module dmem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int INDEX_BITS  = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic [3:0]            byte_en,
   input  logic [INDEX_BITS-1:0] index,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (byte_en[b]) begin
            mem[index][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[index];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data memory responder
// Purpose: accepts one byte/half/word read or write at a time, answers after
//          LATENCY enabled cycles with a one-cycle data_ready (plus access_err
//          for illegal or misaligned requests). Storage lives in dmem_array.
// Ports:   clk, rst (async, active-high), clk_en (global stall)
//          data_rd_en / data_wr_en - request strobes
//          data_rd_wr_ctrl         - access size (00 byte, 01 half, 10 word)
//          addr, data_in           - byte address, right-aligned write data
//          data_out                - right-aligned, zero-extended read data
//          data_ready, access_err  - completion and error pulses
module data_mem_responder
   import riscv_definitions::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        data_rd_en,
   input  logic        data_wr_en,
   input  logic [1:0]  data_rd_wr_ctrl,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        access_err
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   resp_state_t state, next_state;
   logic [3:0]  cnt;

   logic [AW+1:0]          lat_addr;
   logic [1:0]             lat_size;
   logic [WORD_BITS-1:0]   lat_data;
   logic                   lat_rd, lat_wr;

   // Address bits above the storage size alias by design.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[31:AW+2];

   // In IDLE the live inputs are the request (LATENCY = 1 completes on the
   // accepting edge); afterwards only the latched copy is used.
   logic [AW+1:0] cur_addr;
   logic [1:0]    cur_size;
   logic [31:0]   cur_data;
   logic          cur_rd, cur_wr, cur_err;

   always_comb begin
      if (state == IDLE) begin
         cur_addr = addr[AW+1:0];
         cur_size = data_rd_wr_ctrl;
         cur_data = data_in;
         cur_rd   = data_rd_en;
         cur_wr   = data_wr_en;
      end else begin
         cur_addr = lat_addr;
         cur_size = lat_size;
         cur_data = lat_data;
         cur_rd   = lat_rd;
         cur_wr   = lat_wr;
      end
   end

   always_comb begin
      cur_err = cur_rd & cur_wr;
      case (cur_size)
         MEM_BYTE: ;
         MEM_HALF: if (cur_addr[0]) cur_err = 1'b1;
         MEM_WORD: if (cur_addr[1:0] != 2'b00) cur_err = 1'b1;
         default:  cur_err = 1'b1;
      endcase
   end

   always_comb begin
      next_state = state;
      data_ready = 1'b0;
      access_err = 1'b0;
      case (state)
         IDLE: if (data_rd_en || data_wr_en) next_state = (LATENCY == 1) ? RESP : WAIT;
         WAIT: if (cnt == CNT_LAST) next_state = RESP;
         RESP: begin
            next_state = IDLE;
            data_ready = 1'b1;
            access_err = cur_err;
         end
         default: next_state = IDLE;
      endcase
   end

   // Write commit and read capture both happen on the edge that enters RESP.
   logic        enter_resp;
   logic [3:0]  byte_en;
   logic [31:0] wdata, rdata, rd_shift, rd_data;

   assign enter_resp = clk_en && (state != RESP) && (next_state == RESP);
   assign byte_en    = (enter_resp && cur_wr && !cur_err) ? lane_mask(cur_size, cur_addr[1:0]) : 4'b0000;
   assign wdata      = cur_data << {cur_addr[1:0], 3'b000};
   assign rd_shift   = rdata >> {cur_addr[1:0], 3'b000};

   always_comb begin
      case (cur_size)
         MEM_BYTE: rd_data = {24'd0, rd_shift[7:0]};
         MEM_HALF: rd_data = {16'd0, rd_shift[15:0]};
         default:  rd_data = rd_shift;
      endcase
   end

   dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .INDEX_BITS(AW)) u_array (
      .clk     (clk),
      .byte_en (byte_en),
      .index   (cur_addr[AW+1:2]),
      .wdata   (wdata),
      .rdata   (rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         lat_addr <= '0;
         lat_size <= 2'b00;
         lat_data <= '0;
         lat_rd   <= 1'b0;
         lat_wr   <= 1'b0;
         data_out <= '0;
      end else if (clk_en) begin
         state <= next_state;
         cnt   <= (state == WAIT && next_state == WAIT) ? cnt + 4'd1 : 4'd0;
         if (state == IDLE && (data_rd_en || data_wr_en)) begin
            lat_addr <= addr[AW+1:0];
            lat_size <= data_rd_wr_ctrl;
            lat_data <= data_in;
            lat_rd   <= data_rd_en;
            lat_wr   <= data_wr_en;
         end
         // A good write leaves data_out holding its previous value.
         if (enter_resp) begin
            if (cur_err)     data_out <= '0;
            else if (cur_rd) data_out <= rd_data;
         end
      end
   end

endmodule
